// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D miss-port arbiter: FSM states, requester sides and
// the helper that sizes the word index from the line length.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } statetype;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_t;

  localparam int DEFAULT_BSIZE = 4;
  localparam int WORDBITS      = $clog2(DEFAULT_BSIZE);

  function automatic int word_bits(input int bsize);
    return $clog2(bsize);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the two cache miss ports and the shared memory port.
// Handshakes: IReq/DReq are held until the matching Done pulse and dropped on
// the edge that samples it; MemRE/MemWE pulse for one cycle per word and the
// memory answers with a one-cycle MemValid while MemA/MemWD stay stable.
interface mem_arbiter_if #(
  parameter int BSIZE = 4
) ();

  logic                       IReq;
  logic [31:0]                IAddr;
  logic                       DReq;
  logic                       DWE;
  logic [31:0]                DAddr;
  logic [31:0]                DWD;
  logic [31:0]                RData;
  logic [$clog2(BSIZE)-1:0]   WordIdx;
  logic                       IWordValid;
  logic                       DWordValid;
  logic                       IDone;
  logic                       DDone;
  logic                       Busy;
  logic                       MemRE;
  logic                       MemWE;
  logic [31:0]                MemA;
  logic [31:0]                MemWD;
  logic [31:0]                MemRD;
  logic                       MemValid;

  modport master (
    input  IReq, IAddr, DReq, DWE, DAddr, DWD, MemRD, MemValid,
    output RData, WordIdx, IWordValid, DWordValid, IDone, DDone, Busy,
           MemRE, MemWE, MemA, MemWD
  );

  modport slave (
    output IReq, IAddr, DReq, DWE, DAddr, DWD, MemRD, MemValid,
    input  RData, WordIdx, IWordValid, DWordValid, IDone, DDone, Busy,
           MemRE, MemWE, MemA, MemWD
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin grant between the I and D sides; remembers whether D
// won the previous grant so simultaneous requests alternate.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  req_i_i,
  input  logic  req_d_i,
  input  logic  en_i,
  output logic  gnt_o,
  output side_t gnt_side_o
);

  logic last_d_q, last_d_d;

  always_comb begin
    gnt_o = req_i_i | req_d_i;
    if (req_i_i && req_d_i) begin
      gnt_side_o = last_d_q ? SIDE_I : SIDE_D;
    end else begin
      gnt_side_o = req_d_i ? SIDE_D : SIDE_I;
    end
    last_d_d = last_d_q;
    if (en_i && gnt_o) begin
      last_d_d = (gnt_side_o == SIDE_D);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Grants the shared memory port to the I or D miss port and sequences each
// word as its own memory transaction: BSIZE-word line fills or one-word writes.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BSIZE = DEFAULT_BSIZE
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus,
  output statetype      state_o
);

  localparam int WB = word_bits(BSIZE);
  localparam logic [WB-1:0] LAST_IDX = WB'(BSIZE - 1);

  statetype      state_q, state_d;
  side_t         side_q, side_d;
  logic [31:0]   base_q, base_d;
  logic          is_write_q, is_write_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [WB-1:0] word_cnt_q, word_cnt_d;
  logic          mem_re_q, mem_re_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_a_q, mem_a_d;
  logic [31:0]   mem_wd_q, mem_wd_d;
  logic          busy_q, busy_d;

  logic  gnt;
  side_t gnt_side;
  logic  valid_in_wait;

  rr_arb2 u_rr_arb2 (
    .clk        (clk),
    .reset      (reset),
    .req_i_i    (bus.IReq),
    .req_d_i    (bus.DReq),
    .en_i       (state_q == IDLE),
    .gnt_o      (gnt),
    .gnt_side_o (gnt_side)
  );

  assign valid_in_wait = (state_q == WAIT) && bus.MemValid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the next values of the registered memory-side outputs,
  // which are derived from where the FSM is heading.
  always_comb begin
    state_d    = state_q;
    side_d     = side_q;
    base_d     = base_q;
    is_write_d = is_write_q;
    wdata_d    = wdata_q;
    word_cnt_d = word_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (gnt) begin
          state_d    = ISSUE;
          side_d     = gnt_side;
          base_d     = (gnt_side == SIDE_D) ? bus.DAddr : bus.IAddr;
          is_write_d = (gnt_side == SIDE_D) && bus.DWE;
          wdata_d    = bus.DWD;
          word_cnt_d = '0;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.MemValid) begin
          if (is_write_q || (word_cnt_q == LAST_IDX)) begin
            state_d = IDLE;
          end else begin
            state_d    = ISSUE;
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    mem_re_d = (state_d == ISSUE) && !is_write_d;
    mem_we_d = (state_d == ISSUE) && is_write_d;
    mem_a_d  = mem_a_q;
    mem_wd_d = mem_wd_q;
    busy_d   = (state_d != IDLE);
    if (state_d == ISSUE) begin
      if (is_write_d) begin
        mem_a_d  = base_d;
        mem_wd_d = wdata_d;
      end else begin
        mem_a_d = {base_d[31:WB+2], word_cnt_d, 2'b00};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      side_q     <= SIDE_I;
      base_q     <= '0;
      is_write_q <= 1'b0;
      wdata_q    <= '0;
      word_cnt_q <= '0;
      mem_re_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_a_q    <= '0;
      mem_wd_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      side_q     <= side_d;
      base_q     <= base_d;
      is_write_q <= is_write_d;
      wdata_q    <= wdata_d;
      word_cnt_q <= word_cnt_d;
      mem_re_q   <= mem_re_d;
      mem_we_q   <= mem_we_d;
      mem_a_q    <= mem_a_d;
      mem_wd_q   <= mem_wd_d;
      busy_q     <= busy_d;
    end
  end

  // Read data, word strobes and Done are combinational so they line up with
  // the MemValid cycle itself.
  always_comb begin
    bus.RData      = '0;
    bus.WordIdx    = '0;
    bus.IWordValid = 1'b0;
    bus.DWordValid = 1'b0;
    bus.IDone      = 1'b0;
    bus.DDone      = 1'b0;
    if (valid_in_wait && !is_write_q) begin
      bus.RData      = bus.MemRD;
      bus.WordIdx    = word_cnt_q;
      bus.IWordValid = (side_q == SIDE_I);
      bus.DWordValid = (side_q == SIDE_D);
    end
    if (valid_in_wait && (is_write_q || (word_cnt_q == LAST_IDX))) begin
      bus.IDone = (side_q == SIDE_I);
      bus.DDone = (side_q == SIDE_D);
    end
  end

  assign bus.MemRE = mem_re_q;
  assign bus.MemWE = mem_we_q;
  assign bus.MemA  = mem_a_q;
  assign bus.MemWD = mem_wd_q;
  assign bus.Busy  = busy_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a latency-programmable memory model, a
// scoreboard of expected memory requests and requester-side responses.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int BSIZE = 4;
  localparam int WB    = 2;
  localparam int PW    = 3 + WB + 32;
  localparam int MW    = 1 + 32 + 32;

  logic     clk = 1'b0;
  logic     reset = 1'b1;
  statetype state_o;

  mem_arbiter_if #(.BSIZE(BSIZE)) bus ();

  mem_arbiter #(.BSIZE(BSIZE)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (state_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [PW-1:0] exp_q[$];
  logic [MW-1:0] mem_q[$];
  int            issue_cyc[$];
  int            idone_cyc = 0;
  int            ddone_cyc = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [PW-1:0] pkt(input logic done, input logic side_d, input logic word,
                                        input logic [WB-1:0] idx, input logic [31:0] data);
    return {done, side_d, word, idx, data};
  endfunction

  // n_issue memory reads are expected, of which the first n_words complete.
  task automatic push_fill(input logic side_d, input logic [31:0] addr, input int n_issue, input int n_words);
    logic [31:0] a;
    for (int i = 0; i < n_issue; i++) begin
      a = {addr[31:4], 4'h0} + 32'(i * 4);
      mem_q.push_back({1'b0, a, 32'h0});
      if (i < n_words) exp_q.push_back(pkt(i == BSIZE - 1, side_d, 1'b1, WB'(i), mem_data(a)));
    end
  endtask

  task automatic push_write(input logic [31:0] addr, input logic [31:0] data);
    mem_q.push_back({1'b1, addr, data});
    exp_q.push_back(pkt(1'b1, 1'b1, 1'b0, '0, 32'h0));
  endtask

  // Memory model: sees a request at the edge ending its ISSUE cycle and
  // returns MemValid lat cycles after that ISSUE cycle.
  int          lat = 3;
  logic        spur = 1'b0;
  logic        mem_clear = 1'b0;
  logic        m_pend = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_addr = '0;
  logic        m_req;
  logic [31:0] m_a;

  initial begin
    bus.MemValid = 1'b0;
    bus.MemRD    = '0;
  end

  always @(posedge clk) begin
    m_req = bus.MemRE | bus.MemWE;
    m_a   = bus.MemA;
    #1;
    bus.MemValid = 1'b0;
    if (mem_clear) begin
      m_pend = 1'b0;
    end else begin
      if (m_pend) begin
        m_cnt--;
        if (m_cnt == 0) begin
          bus.MemValid = 1'b1;
          bus.MemRD    = mem_data(m_addr);
          m_pend       = 1'b0;
        end
      end
      if (m_req) begin
        m_addr = m_a;
        if (lat == 1) begin
          bus.MemValid = 1'b1;
          bus.MemRD    = mem_data(m_a);
        end else begin
          m_pend = 1'b1;
          m_cnt  = lat - 1;
        end
      end
    end
    if (spur) begin
      bus.MemValid = 1'b1;
      bus.MemRD    = 32'h5A5A_5A5A;
      spur         = 1'b0;
    end
  end

  logic [PW-1:0] sb_exp, sb_act;
  logic [MW-1:0] mq_exp, mq_act;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.MemRE || bus.MemWE) begin
        issue_cyc.push_back(cyc);
        chk("mem_re_we_excl", {79'b0, bus.MemRE & bus.MemWE}, 80'd0);
        mq_act = {bus.MemWE, bus.MemA, bus.MemWE ? bus.MemWD : 32'h0};
        if (mem_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_req unexpected actual=%0h required=none", mq_act);
        end else begin
          mq_exp = mem_q.pop_front();
          chk("mem_req", {15'b0, mq_act}, {15'b0, mq_exp});
        end
      end
      if (bus.IWordValid || bus.DWordValid || bus.IDone || bus.DDone) begin
        if (bus.IDone) idone_cyc = cyc;
        if (bus.DDone) ddone_cyc = cyc;
        sb_act = pkt(bus.IDone | bus.DDone, bus.DWordValid | bus.DDone, bus.IWordValid | bus.DWordValid,
                     (bus.IWordValid | bus.DWordValid) ? bus.WordIdx : '0,
                     (bus.IWordValid | bus.DWordValid) ? bus.RData : 32'h0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL response unexpected actual=%0h required=none", sb_act);
        end else begin
          sb_exp = exp_q.pop_front();
          chk("response", {43'b0, sb_act}, {43'b0, sb_exp});
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    if (bus.IDone) bus.IReq = 1'b0;
    if (bus.DDone) bus.DReq = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while ((bus.IReq || bus.DReq || bus.Busy) && k < 300);
    if (k >= 300) begin
      errors++;
      $display("FAIL %s timeout actual=busy required=idle", name);
    end
    checks++;
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_outs"},
        {41'b0, bus.Busy, bus.MemRE, bus.MemWE, bus.IWordValid, bus.DWordValid, bus.IDone, bus.DDone,
         bus.WordIdx, bus.MemA},
        80'd0);
    chk({name, "_data"}, {16'b0, bus.MemWD, bus.RData}, 80'd0);
    chk({name, "_state"}, {78'b0, state_o}, {78'b0, IDLE});
  endtask

  int g, d, n_re, k;

  initial begin
    bus.IReq = 0; bus.IAddr = 0; bus.DReq = 0; bus.DWE = 0; bus.DAddr = 0; bus.DWD = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // I-only fill at 0x1234, latency 3: grant cycle through Done cycle is 17 cycles.
    tick();
    issue_cyc.delete();
    push_fill(1'b0, 32'h0000_1234, 4, 4);
    g = cyc;
    bus.IAddr = 32'h0000_1234;
    bus.IReq  = 1'b1;
    wait_idle("i_fill");
    chk("i_fill_first_issue", 80'(issue_cyc[0] - g), 80'd1);
    chk("i_fill_issue_count", 80'(issue_cyc.size()), 80'd4);
    chk("i_fill_done_cycles", 80'(idone_cyc - g + 1), 80'd17);

    // D write-through of one word.
    issue_cyc.delete();
    push_write(32'h0000_0040, 32'hDEAD_BEEF);
    g = cyc;
    bus.DAddr = 32'h0000_0040; bus.DWD = 32'hDEAD_BEEF; bus.DWE = 1'b1; bus.DReq = 1'b1;
    wait_idle("d_write");
    chk("d_write_done_cycle", 80'(ddone_cyc - g), 80'd4);
    chk("d_write_issue_count", 80'(issue_cyc.size()), 80'd1);

    // After a fresh reset both rise together: D first; D re-raised right after
    // its Done then loses to the waiting I, and is served afterwards.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    issue_cyc.delete();
    push_write(32'h0000_0080, 32'h1234_5678);
    push_fill(1'b0, 32'h0000_2000, 4, 4);
    push_write(32'h0000_0084, 32'hCAFE_F00D);
    bus.IAddr = 32'h0000_2000; bus.IReq = 1'b1;
    bus.DAddr = 32'h0000_0080; bus.DWD = 32'h1234_5678; bus.DWE = 1'b1; bus.DReq = 1'b1;
    k = 0;
    do begin tick(); k++; end while (bus.DReq && k < 50);
    chk("pair_d_done_seen", 80'(bus.DReq), 80'd0);
    d = cyc;
    tick();
    bus.DAddr = 32'h0000_0084; bus.DWD = 32'hCAFE_F00D; bus.DReq = 1'b1;
    wait_idle("pair");
    chk("pair_i_issue_after_ddone", 80'(issue_cyc[1] - d), 80'd2);
    chk("pair_issue_count", 80'(issue_cyc.size()), 80'd6);

    // D arrives while the I fill is on word 1; the fill must finish first.
    issue_cyc.delete();
    push_fill(1'b0, 32'h0000_3008, 4, 4);
    push_write(32'h0000_0044, 32'h0BAD_F00D);
    bus.IAddr = 32'h0000_3008; bus.IReq = 1'b1;
    k = 0;
    do begin tick(); k++; end while (!(bus.IWordValid && bus.WordIdx == 2'd0) && k < 50);
    bus.DAddr = 32'h0000_0044; bus.DWD = 32'h0BAD_F00D; bus.DWE = 1'b1; bus.DReq = 1'b1;
    wait_idle("no_preempt");
    chk("no_preempt_d_issue", 80'(issue_cyc[4] - idone_cyc), 80'd2);

    // Spurious MemValid while idle is ignored.
    spur = 1'b1;
    tick();
    chk("spurious_outs", {76'b0, bus.IWordValid, bus.DWordValid, bus.IDone, bus.DDone}, 80'd0);
    tick();
    chk("spurious_idle", {78'b0, state_o}, {78'b0, IDLE});
    chk("spurious_busy", {79'b0, bus.Busy}, 80'd0);

    // Latency 1: ISSUE and Valid alternate every cycle.
    lat = 1;
    issue_cyc.delete();
    push_fill(1'b0, 32'h0000_4010, 4, 4);
    g = cyc;
    bus.IAddr = 32'h0000_4010; bus.IReq = 1'b1;
    wait_idle("lat1");
    chk("lat1_done_cycles", 80'(idone_cyc - g + 1), 80'd9);
    for (int i = 1; i < 4; i++) chk("lat1_issue_gap", 80'(issue_cyc[i] - issue_cyc[i-1]), 80'd2);

    // Reset during WAIT of word 2 abandons the fill without a Done.
    lat = 3;
    push_fill(1'b0, 32'h0000_5000, 3, 2);
    bus.IAddr = 32'h0000_5000; bus.IReq = 1'b1;
    n_re = 0;
    k = 0;
    do begin tick(); k++; if (bus.MemRE) n_re++; end while (n_re < 3 && k < 50);
    tick();
    reset = 1'b1; bus.IReq = 1'b0; mem_clear = 1'b1;
    tick();
    check_all_zero("mid_reset");
    reset = 1'b0; mem_clear = 1'b0;
    repeat (5) tick();
    chk("mid_reset_no_done", 80'(exp_q.size()), 80'd0);
    push_fill(1'b0, 32'h0000_6004, 4, 4);
    bus.IAddr = 32'h0000_6004; bus.IReq = 1'b1;
    wait_idle("after_reset_fill");

    chk("final_exp_q_empty", 80'(exp_q.size()), 80'd0);
    chk("final_mem_q_empty", 80'(mem_q.size()), 80'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
